audio_fifo_reader: RTL and testbench

//  Read-side drain for the 24-bit audio sample FIFO (afifo24 read port, rd clock domain).

---
 rtl/audio_fifo_reader_pkg.sv | 22 ++
 rtl/audio_fifo_reader_tick_gen.sv | 29 ++
 rtl/audio_fifo_reader.sv | 145 ++++++++++++++
 tb/tb_audio_fifo_reader.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_fifo_reader_pkg.sv
// Shared definitions for the audio FIFO read-side drain.
// Sample width and the 3-bit reader state encoding.
package audio_fifo_reader_pkg;

    localparam int SAMPLE_W = 24;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PRIME     = 3'd1,
        ST_WAIT_TICK = 3'd2,
        ST_RD_L      = 3'd3,
        ST_CAP_L     = 3'd4,
        ST_RD_R      = 3'd5,
        ST_CAP_R     = 3'd6
    } state_t;

    function automatic logic is_running(state_t s);
        return (s == ST_WAIT_TICK) || (s == ST_RD_L) || (s == ST_CAP_L) ||
               (s == ST_RD_R) || (s == ST_CAP_R);
    endfunction

endpackage

// File: rtl/audio_fifo_reader_tick_gen.sv
// Frame tick divider: one-cycle tick every CLK_DIV clocks.
// Shared by the rx and tx audio paths.
module audio_fifo_reader_tick_gen #(
    parameter int CLK_DIV = 1024
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = (cnt == LAST);

    // free-running 0..CLK_DIV-1 counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/audio_fifo_reader.sv
// Read-side drain of the 24-bit audio FIFO: primes, pops one L/R
// pair per frame tick, repeats the last pair and counts underruns.
module audio_fifo_reader
    import audio_fifo_reader_pkg::*;
#(
    parameter int CLK_DIV     = 1024,
    parameter int PRIME_TICKS = 4,
    parameter int UCNT_W      = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic [SAMPLE_W-1:0] fifo_q,
    input  logic                fifo_empty,
    output logic                fifo_rd_en,
    output logic [SAMPLE_W-1:0] sample_l,
    output logic [SAMPLE_W-1:0] sample_r,
    output logic                sample_valid,
    output logic                underrun,
    output logic [UCNT_W-1:0]   underrun_count,
    output logic                running
);

    localparam int PW = $clog2(PRIME_TICKS + 1);
    localparam logic [PW-1:0] PRIME_LAST = PW'(PRIME_TICKS - 1);

    state_t state, state_n;
    logic [PW-1:0] prime_cnt, prime_n;
    logic [SAMPLE_W-1:0] left_q, left_n;
    logic [SAMPLE_W-1:0] sl_n, sr_n;
    logic valid_n, urun_n;
    logic [UCNT_W-1:0] ucnt_n, ucnt_sat;
    logic tick;

    audio_fifo_reader_tick_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_tick (
        .clk (clk),
        .rst (rst),
        .tick(tick)
    );

    assign ucnt_sat = (&underrun_count) ? underrun_count
                                        : underrun_count + 1'b1;
    assign fifo_rd_en = ((state == ST_RD_L) || (state == ST_RD_R)) &&
                        !fifo_empty;
    assign running = is_running(state);

    // next state, holding register and registered output values
    always_comb begin
        state_n = state;
        prime_n = prime_cnt;
        left_n  = left_q;
        sl_n    = sample_l;
        sr_n    = sample_r;
        valid_n = 1'b0;
        urun_n  = 1'b0;
        ucnt_n  = underrun_count;
        unique case (state)
            ST_IDLE: begin
                if (enable) begin
                    state_n = ST_PRIME;
                    prime_n = '0;
                end
            end
            ST_PRIME: begin
                if (!enable) begin
                    state_n = ST_IDLE;
                end else if (tick) begin
                    if (fifo_empty) begin
                        prime_n = '0;
                    end else if (prime_cnt == PRIME_LAST) begin
                        state_n = ST_WAIT_TICK;
                    end else begin
                        prime_n = prime_cnt + 1'b1;
                    end
                end
            end
            ST_WAIT_TICK: begin
                if (!enable) begin
                    state_n = ST_IDLE;
                end else if (tick) begin
                    state_n = ST_RD_L;
                end
            end
            ST_RD_L: begin
                if (!fifo_empty) begin
                    state_n = ST_CAP_L;
                end else begin
                    valid_n = 1'b1;
                    urun_n  = 1'b1;
                    ucnt_n  = ucnt_sat;
                    prime_n = '0;
                    state_n = ST_PRIME;
                end
            end
            ST_CAP_L: begin
                left_n  = fifo_q;
                state_n = ST_RD_R;
            end
            ST_RD_R: begin
                // stall here so L/R never swap; a missed frame counts as underrun
                if (!fifo_empty) begin
                    state_n = ST_CAP_R;
                end else if (tick) begin
                    urun_n = 1'b1;
                    ucnt_n = ucnt_sat;
                end
            end
            ST_CAP_R: begin
                sl_n    = left_q;
                sr_n    = fifo_q;
                valid_n = 1'b1;
                state_n = ST_WAIT_TICK;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // state and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= ST_IDLE;
            prime_cnt      <= '0;
            left_q         <= '0;
            sample_l       <= '0;
            sample_r       <= '0;
            sample_valid   <= 1'b0;
            underrun       <= 1'b0;
            underrun_count <= '0;
        end else begin
            state          <= state_n;
            prime_cnt      <= prime_n;
            left_q         <= left_n;
            sample_l       <= sl_n;
            sample_r       <= sr_n;
            sample_valid   <= valid_n;
            underrun       <= urun_n;
            underrun_count <= ucnt_n;
        end
    end

endmodule

// File: tb/tb_audio_fifo_reader.sv
// Bench for audio_fifo_reader: FIFO model, frame-level reference
// model compared every cycle, plus directed literal checks.
module tb_audio_fifo_reader;

    localparam int CLK_DIV     = 16;
    localparam int PRIME_TICKS = 2;
    localparam int UCNT_W      = 2;
    localparam int CMAX        = (1 << UCNT_W) - 1;

    localparam int M_IDLE  = 0;
    localparam int M_PRIME = 1;
    localparam int M_ARMED = 2;
    localparam int M_FRAME = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic enable = 1'b0;
    logic [23:0] fifo_q = '0;
    logic fifo_empty;
    logic fifo_rd_en;
    logic [23:0] sample_l, sample_r;
    logic sample_valid, underrun, running;
    logic [UCNT_W-1:0] underrun_count;

    audio_fifo_reader #(
        .CLK_DIV    (CLK_DIV),
        .PRIME_TICKS(PRIME_TICKS),
        .UCNT_W     (UCNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .fifo_q        (fifo_q),
        .fifo_empty    (fifo_empty),
        .fifo_rd_en    (fifo_rd_en),
        .sample_l      (sample_l),
        .sample_r      (sample_r),
        .sample_valid  (sample_valid),
        .underrun      (underrun),
        .underrun_count(underrun_count),
        .running       (running)
    );

    always #5 clk = ~clk;

    logic [23:0] mem [0:4095];
    int wp = 0;
    int rp = 0;
    assign fifo_empty = (wp == rp);

    int passed = 0;
    int total = 0;

    int mode = M_IDLE;
    int streak = 0;
    int tcnt = 0;
    int need = 0;
    bit win = 0, gap = 0, pend_out = 0;
    logic [23:0] lw = '0, rw = '0, exp_l = '0, exp_r = '0;
    bit exp_valid = 0, exp_urun = 0;
    int exp_cnt = 0;
    int cyc = 0;
    int last_tick = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic logic [63:0] outs();
        return 64'({running, fifo_rd_en, sample_valid, underrun,
                    underrun_count, sample_l, sample_r});
    endfunction

    task automatic push(input logic [23:0] w);
        if (wp < 4096) begin
            mem[wp] = w;
            wp++;
        end
    endtask

    // reference model (frame level) and FIFO read port
    always @(posedge clk or posedge rst) begin : mstep
        bit tk, popping;
        logic [23:0] w;
        if (rst) begin
            mode = M_IDLE; streak = 0; tcnt = 0; need = 0;
            win = 0; gap = 0; pend_out = 0;
            exp_l = '0; exp_r = '0; exp_valid = 0; exp_urun = 0;
            exp_cnt = 0;
            rp <= wp;
            fifo_q <= '0;
        end else begin
            tk = (tcnt == CLK_DIV - 1);
            if (tk) last_tick = cyc;
            tcnt = tk ? 0 : tcnt + 1;
            popping = win && !fifo_empty;
            w = mem[rp[11:0]];
            exp_valid = 0;
            exp_urun = 0;
            case (mode)
                M_IDLE: if (enable) begin mode = M_PRIME; streak = 0; end
                M_PRIME: begin
                    if (!enable) mode = M_IDLE;
                    else if (tk) begin
                        streak = fifo_empty ? 0 : streak + 1;
                        if (streak >= PRIME_TICKS) mode = M_ARMED;
                    end
                end
                M_ARMED: begin
                    if (!enable) mode = M_IDLE;
                    else if (tk) begin mode = M_FRAME; need = 2; win = 1; end
                end
                default: begin
                    if (win) begin
                        if (popping) begin
                            win = 0;
                            if (need == 2) begin lw = w; need = 1; gap = 1; end
                            else begin rw = w; need = 0; pend_out = 1; end
                        end else if (need == 2) begin
                            win = 0; exp_valid = 1; exp_urun = 1;
                            exp_cnt = (exp_cnt == CMAX) ? CMAX : exp_cnt + 1;
                            mode = M_PRIME; streak = 0;
                        end else if (tk) begin
                            exp_urun = 1;
                            exp_cnt = (exp_cnt == CMAX) ? CMAX : exp_cnt + 1;
                        end
                    end else if (gap) begin
                        gap = 0; win = 1;
                    end else if (pend_out) begin
                        pend_out = 0; exp_l = lw; exp_r = rw;
                        exp_valid = 1; mode = M_ARMED;
                    end
                end
            endcase
            if (fifo_rd_en && !fifo_empty) begin
                fifo_q <= mem[rp[11:0]];
                rp <= rp + 1;
            end
            cyc++;
        end
    end

    // every-cycle comparison against the model
    always @(posedge clk) begin
        logic [63:0] e;
        #1;
        e = 64'({(mode == M_ARMED) || (mode == M_FRAME),
                 win && !fifo_empty, exp_valid, exp_urun,
                 UCNT_W'(exp_cnt), exp_l, exp_r});
        chk("cycle", outs(), e);
    end

    task automatic wait_valid(input int maxc, input string nm);
        bit found = 0;
        for (int i = 0; i < maxc && !found; i++) begin
            @(posedge clk); #1;
            if (sample_valid) found = 1;
        end
        chk(nm, 64'(found), 64'd1);
    endtask

    task automatic wait_rd(input int maxc, input string nm);
        bit found = 0;
        for (int i = 0; i < maxc && !found; i++) begin
            @(posedge clk); #1;
            if (fifo_rd_en) found = 1;
        end
        chk(nm, 64'(found), 64'd1);
    endtask

    initial begin
        bit saw_rd;
        repeat (3) @(negedge clk);
        chk("reset_outputs", outs(), 64'd0);
        rst = 1'b0;
        enable = 1'b1;

        // never leaves PRIME with an empty FIFO
        saw_rd = 0;
        repeat (10 * CLK_DIV) begin
            @(negedge clk);
            saw_rd = saw_rd | fifo_rd_en;
        end
        chk("t1_running", 64'(running), 64'd0);
        chk("t1_no_rd", 64'(saw_rd), 64'd0);

        // preloaded pairs
        for (int i = 1; i <= 8; i++) push(24'(i));
        for (int p = 0; p < 4; p++) begin
            wait_valid(6 * CLK_DIV, "t2_valid_seen");
            chk("t2_pair", 64'({sample_l, sample_r}),
                64'({24'(2 * p + 1), 24'(2 * p + 2)}));
            chk("t2_latency", 64'(cyc - last_tick), 64'd5);
        end

        // drained: repeat last pair
        wait_valid(2 * CLK_DIV, "t3_valid_seen");
        chk("t3_underrun", 64'(underrun), 64'd1);
        chk("t3_pair", 64'({sample_l, sample_r}), 64'({24'd7, 24'd8}));
        chk("t3_count", 64'(underrun_count), 64'd1);
        chk("t3_running", 64'(running), 64'd0);

        // L present, R late: stall across one tick
        @(negedge clk);
        push(24'hA00001);
        wait_rd(5 * CLK_DIV, "t4_l_pop");
        repeat (19) @(negedge clk);
        push(24'hA00002);
        wait_valid(2 * CLK_DIV, "t4_valid_seen");
        chk("t4_pair", 64'({sample_l, sample_r}),
            64'({24'hA00001, 24'hA00002}));
        chk("t4_count", 64'(underrun_count), 64'd2);

        // enable dropped during CAP_L
        @(negedge clk);
        push(24'hB00001);
        push(24'hB00002);
        wait_rd(2 * CLK_DIV, "t5_l_pop");
        @(negedge clk);
        @(negedge clk);
        enable = 1'b0;
        wait_valid(8, "t5_valid_seen");
        chk("t5_pair", 64'({sample_l, sample_r}),
            64'({24'hB00001, 24'hB00002}));
        repeat (3) @(negedge clk);
        chk("t5_idle", 64'(running), 64'd0);

        // randomized traffic with occasional enable drops
        enable = 1'b1;
        repeat (1500) begin
            @(negedge clk);
            if ($urandom_range(0, 8) == 0) push(24'($urandom));
            if ($urandom_range(0, 299) == 0) enable = ~enable;
        end

        // async reset while stalled in RD_R
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        enable = 1'b1;
        push(24'hC00001);
        push(24'hC00002);
        push(24'hC00003);
        wait_valid(5 * CLK_DIV, "t6_valid_seen");
        chk("t6_pair", 64'({sample_l, sample_r}),
            64'({24'hC00001, 24'hC00002}));
        wait_rd(2 * CLK_DIV, "t6_l_pop");
        repeat (CLK_DIV) begin @(posedge clk); #1; end
        chk("t6_pre_count", 64'(underrun_count), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_async_rst", outs(), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // counter saturation
        push(24'hD00001);
        wait_rd(5 * CLK_DIV, "t7_l_pop");
        repeat (6 * CLK_DIV) @(negedge clk);
        chk("t7_saturate", 64'(underrun_count), 64'd3);
        push(24'hD00002);
        wait_valid(2 * CLK_DIV, "t7_valid_seen");
        chk("t7_pair", 64'({sample_l, sample_r}),
            64'({24'hD00001, 24'hD00002}));

        repeat (4) @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
